// File: rtl/gpio_irq_if.sv
// Simple bus interface shared by the bus master and the slave peripherals.
// rw = 1 selects a read, rw = 0 selects a write. addr is a word address.
// as_ is the active-low address strobe. rd_data is returned by the slave.
interface simple_bus_io #(
  parameter int DATA_W = 32
);

  logic              as_;
  logic              rw;
  logic [3:0]        addr;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] rd_data;

  modport master (
    output as_,
    output rw,
    output addr,
    output wr_data,
    input  rd_data
  );

  modport slave (
    input  as_,
    input  rw,
    input  addr,
    input  wr_data,
    output rd_data
  );

endinterface

// File: rtl/gpio_irq.sv
// GPIO controller with per-pin direction and atomic set/clear/toggle output
// writes. Every pin passes through an input synchroniser into an edge detector.
// Rising and falling edges are captured in sticky write-1-to-clear status bits.
// The status bits are masked by irq_en and ORed into one level interrupt.
// Output pins read back through the synchroniser, so IN always shows the
// actual pin level and edges on output pins are detected as well.
module gpio_irq #(
  parameter int IO_W        = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cs_,
  simple_bus_io.slave     bus,
  output logic            rdy_,
  inout  wire  [IO_W-1:0] gpio_io,
  output logic            irq
);

  // Register word addresses.
  localparam logic [3:0] ADDR_IN      = 4'h0;
  localparam logic [3:0] ADDR_OUT     = 4'h1;
  localparam logic [3:0] ADDR_DIR     = 4'h2;
  localparam logic [3:0] ADDR_OUT_SET = 4'h3;
  localparam logic [3:0] ADDR_OUT_CLR = 4'h4;
  localparam logic [3:0] ADDR_OUT_TGL = 4'h5;
  localparam logic [3:0] ADDR_RISE_EN = 4'h6;
  localparam logic [3:0] ADDR_FALL_EN = 4'h7;
  localparam logic [3:0] ADDR_IRQ_EN  = 4'h8;
  localparam logic [3:0] ADDR_STATUS  = 4'h9;

  localparam logic RW_READ = 1'b1;

  // Programmable state.
  logic [IO_W-1:0] out_reg;
  logic [IO_W-1:0] dir;
  logic [IO_W-1:0] rise_en;
  logic [IO_W-1:0] fall_en;
  logic [IO_W-1:0] irq_en;
  logic [IO_W-1:0] status;

  // Input path. The last stage of the synchroniser is the value software sees.
  // hist is one sample older and is used for edge detection.
  logic [IO_W-1:0] sync_ff [SYNC_STAGES];
  logic [IO_W-1:0] sync;
  logic [IO_W-1:0] hist;

  // Edge events and next status value.
  logic [IO_W-1:0] rise;
  logic [IO_W-1:0] fall;
  logic [IO_W-1:0] status_clr;
  logic [IO_W-1:0] status_next;

  // Bus decode.
  logic              acc;
  logic              rd_acc;
  logic              wr_acc;
  logic [IO_W-1:0]   wd;
  logic [IO_W-1:0]   rd_val;
  logic [DATA_W-1:0] rd_next;

  assign acc    = !cs_ && !bus.as_;
  assign rd_acc = acc && (bus.rw == RW_READ);
  assign wr_acc = acc && (bus.rw != RW_READ);
  assign wd     = bus.wr_data[IO_W-1:0];

  // Write data bits above the pin count have no meaning for this block.
  if (DATA_W > IO_W) begin : g_wr_hi
    logic unused_wr_hi;
    assign unused_wr_hi = ^bus.wr_data[DATA_W-1:IO_W];
  end

  // Each pin is driven only while its direction bit selects output.
  for (genvar i = 0; i < IO_W; i++) begin : g_pin
    assign gpio_io[i] = dir[i] ? out_reg[i] : 1'bz;
  end

  assign sync = sync_ff[SYNC_STAGES-1];

  // Shift pin levels through the synchroniser and keep one sample of history.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_ff[s] <= '0;
      end
      hist <= '0;
    end else begin
      sync_ff[0] <= gpio_io;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_ff[s] <= sync_ff[s-1];
      end
      hist <= sync;
    end
  end

  // Qualified edges. The enables gate new events only, never existing status.
  assign rise = sync & ~hist & rise_en;
  assign fall = ~sync & hist & fall_en;

  // W1C clear mask and next status. New events are ORed in last, so a set
  // wins over a clear hitting the same bit in the same cycle.
  always_comb begin
    status_clr = '0;
    if (wr_acc && (bus.addr == ADDR_STATUS)) begin
      status_clr = wd;
    end
    status_next = (status & ~status_clr) | rise | fall;
  end

  // Read multiplexer. Write-only and unmapped addresses return zero.
  always_comb begin
    rd_val = '0;
    case (bus.addr)
      ADDR_IN:      rd_val = sync;
      ADDR_OUT:     rd_val = out_reg;
      ADDR_DIR:     rd_val = dir;
      ADDR_RISE_EN: rd_val = rise_en;
      ADDR_FALL_EN: rd_val = fall_en;
      ADDR_IRQ_EN:  rd_val = irq_en;
      ADDR_STATUS:  rd_val = status;
      default:      rd_val = '0;
    endcase
    rd_next              = '0;
    rd_next[IO_W-1:0]    = rd_val;
  end

  // Bus response: one-cycle ready after every access, read data only on reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_        <= 1'b1;
      bus.rd_data <= '0;
    end else begin
      rdy_        <= !acc;
      bus.rd_data <= rd_acc ? rd_next : '0;
    end
  end

  // Register writes and status capture. Reset has priority, so an access
  // that coincides with reset never reaches the registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg <= '0;
      dir     <= '0;
      rise_en <= '0;
      fall_en <= '0;
      irq_en  <= '0;
      status  <= '0;
    end else begin
      if (wr_acc) begin
        case (bus.addr)
          ADDR_OUT:     out_reg <= wd;
          ADDR_DIR:     dir     <= wd;
          ADDR_OUT_SET: out_reg <= out_reg | wd;
          ADDR_OUT_CLR: out_reg <= out_reg & ~wd;
          ADDR_OUT_TGL: out_reg <= out_reg ^ wd;
          ADDR_RISE_EN: rise_en <= wd;
          ADDR_FALL_EN: fall_en <= wd;
          ADDR_IRQ_EN:  irq_en  <= wd;
          default:      ;
        endcase
      end
      status <= status_next;
    end
  end

  assign irq = |(status & irq_en);

endmodule

// File: tb/tb_gpio_irq.sv
// Testbench for gpio_irq. A directed vector table and hand-written timing
// sequences are followed by a randomized run, with a reference model
// shadowing the design on every clock.
module tb_gpio_irq;

  localparam int IO_W        = 16;
  localparam int SYNC        = 2;
  localparam int DATA_W      = 32;
  localparam int RAND_CYCLES = 800;

  logic            clk = 1'b0;
  logic            rst;
  logic            cs_;
  logic            rdy_;
  logic            irq;
  wire  [IO_W-1:0] gpio_io;
  logic [IO_W-1:0] tb_en;
  logic [IO_W-1:0] tb_val;

  simple_bus_io #(.DATA_W(DATA_W)) bus_if ();

  gpio_irq #(
    .IO_W        (IO_W),
    .SYNC_STAGES (SYNC),
    .DATA_W      (DATA_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cs_     (cs_),
    .bus     (bus_if),
    .rdy_    (rdy_),
    .gpio_io (gpio_io),
    .irq     (irq)
  );

  // External drivers act on the pins the design leaves as inputs.
  for (genvar i = 0; i < IO_W; i++) begin : g_ext
    assign gpio_io[i] = tb_en[i] ? tb_val[i] : 1'bz;
  end

  always #5 clk = ~clk;

  // Reference model state.
  logic [IO_W-1:0]   m_out, m_dir, m_rise, m_fall, m_irqen, m_status;
  logic [DATA_W-1:0] m_rd;
  logic              m_rdy;
  logic [IO_W-1:0]   samples[$];

  int checks   = 0;
  int failures = 0;

  typedef enum logic [1:0] {OP_RST, OP_RD, OP_WR} op_e;

  typedef struct {
    op_e         op;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic [15:0] pins;
    logic [31:0] exp_rd;
    logic        exp_irq;
    int          idle;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    end
  endtask

  // Pin level sampled on edge number idx since reset; nothing before reset.
  function automatic logic [IO_W-1:0] sample_at(input int idx);
    if (idx < 0 || idx >= samples.size()) return '0;
    return samples[idx];
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [IO_W-1:0] pin, s_now, s_old, ev, wd, rd;
    logic            acc;
    int              n;
    if (rst) begin
      m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_irqen = '0; m_status = '0;
      m_rd  = '0; m_rdy = 1'b1;
      samples.delete();
      return;
    end
    n     = samples.size();
    pin   = (m_dir & m_out) | (~m_dir & tb_val);
    s_now = sample_at(n - SYNC);
    s_old = sample_at(n - SYNC - 1);
    ev    = (s_now & ~s_old & m_rise) | (~s_now & s_old & m_fall);
    acc   = !cs_ && !bus_if.as_;
    wd    = bus_if.wr_data[IO_W-1:0];
    rd    = '0;
    if (acc && bus_if.rw) begin
      case (bus_if.addr)
        4'h0: rd = s_now;
        4'h1: rd = m_out;
        4'h2: rd = m_dir;
        4'h6: rd = m_rise;
        4'h7: rd = m_fall;
        4'h8: rd = m_irqen;
        4'h9: rd = m_status;
        default: rd = '0;
      endcase
    end
    if (acc && !bus_if.rw) begin
      case (bus_if.addr)
        4'h1: m_out    = wd;
        4'h2: m_dir    = wd;
        4'h3: m_out    = m_out | wd;
        4'h4: m_out    = m_out & ~wd;
        4'h5: m_out    = m_out ^ wd;
        4'h6: m_rise   = wd;
        4'h7: m_fall   = wd;
        4'h8: m_irqen  = wd;
        4'h9: m_status = m_status & ~wd;
        default: ;
      endcase
    end
    m_status = m_status | ev;
    m_rd     = DATA_W'(rd);
    m_rdy    = !acc;
    samples.push_back(pin);
  endtask

  task automatic check_output();
    logic [IO_W-1:0] exp_pin;
    exp_pin = (m_dir & m_out) | (~m_dir & tb_val);
    check("rd_data", bus_if.rd_data, m_rd);
    check("rdy_", 32'(rdy_), 32'(m_rdy));
    check("irq", 32'(irq), 32'(|(m_status & m_irqen)));
    check("gpio_io", 32'(gpio_io), 32'(exp_pin));
  endtask

  // One clock: model update, edge, hand undriven pins to the bench, compare.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    tb_en = ~m_dir;
    #1;
    check_output();
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // One bus access lasting a single clock.
  task automatic apply_stimulus(input logic rw, input logic [3:0] addr, input logic [31:0] wd);
    cs_            = 1'b0;
    bus_if.as_     = 1'b0;
    bus_if.rw      = rw;
    bus_if.addr    = addr;
    bus_if.wr_data = wd;
    cycle();
    cs_            = 1'b1;
    bus_if.as_     = 1'b1;
    bus_if.rw      = 1'b1;
    bus_if.wr_data = '0;
  endtask

  task automatic read_expect(input string name, input logic [3:0] addr, input logic [31:0] exp_v);
    apply_stimulus(1'b1, addr, '0);
    check(name, bus_if.rd_data, exp_v);
  endtask

  task automatic add_vec(input op_e op, input logic [3:0] addr, input logic [31:0] wd,
                         input logic [15:0] pins, input logic [31:0] exp_rd,
                         input logic exp_irq, input int n_idle);
    vec_t v;
    v.op = op; v.addr = addr; v.wd = wd; v.pins = pins;
    v.exp_rd = exp_rd; v.exp_irq = exp_irq; v.idle = n_idle;
    vecs.push_back(v);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; cs_ = 1'b1;
    bus_if.as_ = 1'b1; bus_if.rw = 1'b1; bus_if.addr = '0; bus_if.wr_data = '0;
    tb_en = '1; tb_val = '0;
    m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_irqen = '0; m_status = '0;
    m_rd = '0; m_rdy = 1'b1;

    // Reset and register readback.
    add_vec(OP_RST, 4'h0, 32'h0, 16'hA5C3, 32'h0, 1'b0, 3);
    add_vec(OP_RD,  4'h0, 32'h0, 16'hA5C3, 32'h0000_A5C3, 1'b0, 0);
    for (int a = 1; a <= 9; a++) add_vec(OP_RD, 4'(a), 32'h0, 16'hA5C3, 32'h0, 1'b0, 0);
    add_vec(OP_RD,  4'hA, 32'h0, 16'hA5C3, 32'h0, 1'b0, 0);
    add_vec(OP_RD,  4'hF, 32'h0, 16'hA5C3, 32'h0, 1'b0, 0);
    // Output operations.
    add_vec(OP_WR,  4'h2, 32'hFFFF_00FF, 16'hA5C3, 32'h0, 1'b0, 0);
    add_vec(OP_WR,  4'h1, 32'h0000_00F0, 16'hA5C3, 32'h0, 1'b0, 0);
    add_vec(OP_WR,  4'h3, 32'h0000_000F, 16'hA5C3, 32'h0, 1'b0, 0);
    add_vec(OP_RD,  4'h1, 32'h0, 16'hA5C3, 32'h0000_00FF, 1'b0, 0);
    add_vec(OP_WR,  4'h4, 32'h0000_0081, 16'hA5C3, 32'h0, 1'b0, 0);
    add_vec(OP_RD,  4'h1, 32'h0, 16'hA5C3, 32'h0000_007E, 1'b0, 0);
    add_vec(OP_WR,  4'h5, 32'h0000_00FF, 16'hA5C3, 32'h0, 1'b0, 2);
    add_vec(OP_RD,  4'h1, 32'h0, 16'hA5C3, 32'h0000_0081, 1'b0, 0);
    add_vec(OP_RD,  4'h0, 32'h0, 16'hA5C3, 32'h0000_A581, 1'b0, 0);
    add_vec(OP_WR,  4'h3, 32'h0000_FF00, 16'h0000, 32'h0, 1'b0, 3);
    add_vec(OP_RD,  4'h0, 32'h0, 16'h0000, 32'h0000_0081, 1'b0, 0);
    add_vec(OP_RD,  4'h1, 32'h0, 16'h0000, 32'h0000_FF81, 1'b0, 0);
    add_vec(OP_RD,  4'h2, 32'h0, 16'h0000, 32'h0000_00FF, 1'b0, 0);
    // Status capture and interrupt masking.
    add_vec(OP_WR,  4'h2, 32'h0, 16'h0000, 32'h0, 1'b0, 4);
    add_vec(OP_WR,  4'h6, 32'h0000_0003, 16'h0000, 32'h0, 1'b0, 0);
    add_vec(OP_WR,  4'h7, 32'h0000_0003, 16'h0003, 32'h0, 1'b0, 4);
    add_vec(OP_RD,  4'h9, 32'h0, 16'h0003, 32'h0000_0003, 1'b0, 0);
    add_vec(OP_RD,  4'h8, 32'h0, 16'h0003, 32'h0, 1'b0, 0);
    add_vec(OP_WR,  4'h8, 32'h0000_0002, 16'h0003, 32'h0, 1'b1, 0);
    add_vec(OP_WR,  4'h6, 32'h0, 16'h0003, 32'h0, 1'b1, 0);
    add_vec(OP_WR,  4'h7, 32'h0, 16'h0000, 32'h0, 1'b1, 4);
    add_vec(OP_RD,  4'h9, 32'h0, 16'h0000, 32'h0000_0003, 1'b1, 0);
    add_vec(OP_WR,  4'h8, 32'h0, 16'h0000, 32'h0, 1'b0, 0);
    add_vec(OP_RD,  4'h9, 32'h0, 16'h0000, 32'h0000_0003, 1'b0, 0);
    add_vec(OP_WR,  4'h8, 32'h0000_0003, 16'h0000, 32'h0, 1'b1, 0);
    add_vec(OP_WR,  4'h9, 32'h0000_0001, 16'h0000, 32'h0, 1'b1, 0);
    add_vec(OP_RD,  4'h9, 32'h0, 16'h0000, 32'h0000_0002, 1'b1, 0);
    add_vec(OP_WR,  4'h9, 32'hFFFF_FFFF, 16'h0000, 32'h0, 1'b0, 0);
    add_vec(OP_RD,  4'h9, 32'h0, 16'h0000, 32'h0, 1'b0, 0);

    foreach (vecs[i]) begin
      tb_val = vecs[i].pins;
      case (vecs[i].op)
        OP_RST: begin
          rst = 1'b1;
          idle(2);
          rst = 1'b0;
        end
        OP_RD:   apply_stimulus(1'b1, vecs[i].addr, vecs[i].wd);
        default: apply_stimulus(1'b0, vecs[i].addr, vecs[i].wd);
      endcase
      check($sformatf("vec%0d rd_data", i), bus_if.rd_data, vecs[i].exp_rd);
      check($sformatf("vec%0d irq", i), 32'(irq), 32'(vecs[i].exp_irq));
      idle(vecs[i].idle);
    end

    // Rising edge on pin 8: irq exactly SYNC edges after the first sampling edge.
    apply_stimulus(1'b0, 4'h6, 32'h0000_0100);
    apply_stimulus(1'b0, 4'h8, 32'h0000_0100);
    tb_val[8] = 1'b1;
    for (int j = 0; j <= SYNC; j++) begin
      cycle();
      check($sformatf("rise latency edge%0d irq", j), 32'(irq), 32'(j == SYNC));
    end
    read_expect("rise status", 4'h9, 32'h0000_0100);
    tb_val[8] = 1'b0;
    idle(4);
    read_expect("fall ignored status", 4'h9, 32'h0000_0100);
    check("fall ignored irq", 32'(irq), 32'd1);

    // W1C semantics.
    apply_stimulus(1'b0, 4'h9, 32'h0);
    read_expect("w1c zero status", 4'h9, 32'h0000_0100);
    apply_stimulus(1'b0, 4'h9, 32'h0000_0100);
    check("w1c clear irq", 32'(irq), 32'd0);
    read_expect("w1c clear status", 4'h9, 32'h0);

    // Collision: event lands on the same edge as the W1C write.
    tb_val[8] = 1'b1;
    idle(SYNC);
    apply_stimulus(1'b0, 4'h9, 32'h0000_0100);
    read_expect("collision status", 4'h9, 32'h0000_0100);
    check("collision irq", 32'(irq), 32'd1);

    // Reset in the middle of a write.
    apply_stimulus(1'b0, 4'h2, 32'h0000_FFFF);
    tb_val = 16'hFFFF;
    rst = 1'b1; cs_ = 1'b0; bus_if.as_ = 1'b0; bus_if.rw = 1'b0;
    bus_if.addr = 4'h1; bus_if.wr_data = 32'h0000_FFFF;
    cycle();
    check("rst abort rdy_", 32'(rdy_), 32'd1);
    check("rst abort irq", 32'(irq), 32'd0);
    cs_ = 1'b1; bus_if.as_ = 1'b1; bus_if.rw = 1'b1; bus_if.wr_data = '0;
    cycle();
    rst = 1'b0;
    idle(5);
    read_expect("rst out", 4'h1, 32'h0);
    read_expect("rst dir", 4'h2, 32'h0);
    read_expect("rst status", 4'h9, 32'h0);
    read_expect("rst in", 4'h0, 32'h0000_FFFF);
    check("rst pins released", 32'(gpio_io), 32'h0000_FFFF);
    check("rst irq", 32'(irq), 32'd0);

    // Randomized traffic against the model.
    for (int r = 0; r < RAND_CYCLES; r++) begin
      rst = ($urandom_range(99, 0) == 0);
      if ($urandom_range(3, 0) == 0) tb_val = tb_val ^ 16'($urandom_range(65535, 0));
      if ($urandom_range(1, 0) == 1) begin
        cs_ = 1'b0; bus_if.as_ = 1'b0;
      end else begin
        cs_ = 1'($urandom_range(1, 0)); bus_if.as_ = 1'b1;
      end
      bus_if.rw      = 1'($urandom_range(1, 0));
      bus_if.addr    = 4'($urandom_range(11, 0));
      bus_if.wr_data = $urandom;
      cycle();
    end
    rst = 1'b0; cs_ = 1'b1; bus_if.as_ = 1'b1;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_irq.md
Name: gpio_irq

Overview:
- Parametrised GPIO controller on the simple bus, slave side, with IO_W bidirectional pins.
- Each pin has a direction control, atomic set/clear/toggle writes for the output, an input synchroniser, and rising/falling edge detection.
- Detected edges are held in sticky, write-1-to-clear status bits that feed a single level interrupt to the interrupt controller.

Parameters:
- IO_W, 16, number of bidirectional pins (1..32).
- SYNC_STAGES, 2, flops in the input synchroniser (2..4).
- DATA_W, 32, bus data width; must be at least IO_W.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- cs_  in  1  active-low chip select from the bus decoder.
- bus  simple_bus_io.slave  -  uses as_ (active-low strobe), rw, addr, wr_data[DATA_W], rd_data[DATA_W].
- rdy_  out  1  active-low ready.
- gpio_io  inout  IO_W  pins.
- irq  out  1  level interrupt, high while any enabled status bit is set.

Behaviour:
- Reset: a synchronous, active-high rst clears all of the following on the clock edge:
  - rd_data=0 and rdy_=1.
  - out_reg=0, dir=0 (all pins are inputs).
  - rise_en=0, fall_en=0, irq_en=0, status=0.
  - All synchroniser flops and the edge-history flop are cleared.
  - irq=0 in the cycle after the reset edge.
  - Asserting rst mid-access aborts the access: rdy_ goes high and no register is written.
- Pin drive: gpio_io[i] = dir[i] ? out_reg[i] : 'z.
- Synchroniser:
  - sync[i] is gpio_io[i] after SYNC_STAGES flops.
  - hist[i] is sync[i] delayed by one more flop.
  - Output pins read back through the synchroniser as their actual pin level.
- Access detect: acc = !cs_ && !as_.
- Ready: rdy_ is registered; it is 0 in the cycle after any clock where acc holds, otherwise 1. This gives one-cycle latency for both reads and writes.
- Reads (acc && rw==READ): rd_data is registered with the addressed value, zero-extended to DATA_W.
  - In every other cycle rd_data=0.
  - Unmapped addresses read 0.
- Writes (acc && rw==WRITE) use wr_data[IO_W-1:0]; bits above IO_W are ignored. Writes to RO or unmapped addresses have no effect.
- Register map (word address in addr):
  - 0x0 IN, RO: sync.
  - 0x1 OUT, RW: out_reg.
  - 0x2 DIR, RW: 1 = output.
  - 0x3 OUT_SET, WO: out_reg |= wd. Reads 0.
  - 0x4 OUT_CLR, WO: out_reg &= ~wd. Reads 0.
  - 0x5 OUT_TGL, WO: out_reg ^= wd. Reads 0.
  - 0x6 RISE_EN, RW.
  - 0x7 FALL_EN, RW.
  - 0x8 IRQ_EN, RW.
  - 0x9 STATUS, RW1C: writing 1 clears a bit, writing 0 has no effect.
- Edge events:
  - rise[i] = sync[i] & ~hist[i] & rise_en[i].
  - fall[i] = ~sync[i] & hist[i] & fall_en[i].
  - On rise[i]|fall[i], status[i] is set on that clock edge, for input and output pins alike.
  - Latency: a pin transition that is stable before edge k is visible in IN after edge k+SYNC_STAGES-1. The matching status bit sets at edge k+SYNC_STAGES.
- Set/clear collision: if an edge event and a W1C on the same bit occur in the same cycle, set wins and the bit ends at 1.
- Enables do not clear history: clearing rise_en/fall_en stops new events only; status already set is retained.
- irq = |(status & irq_en), combinational from registers.
  - Clearing irq_en masks irq without clearing status.
  - Setting irq_en over pending status raises irq immediately.
- Back-to-back accesses: acc held across consecutive cycles performs one access per cycle, and rdy_ stays 0.

Test Plan:
1. Reset, IO_W=16:
   - Assert rst for 2 cycles.
   - Read 0x0..0x9 -> DIR, OUT, STATUS, RISE_EN, FALL_EN and IRQ_EN read 0; OUT_SET/CLR/TGL read 0; IN reads the external pin levels; irq=0; gpio_io all 'z.
   - Every read returns rdy_=0 exactly one cycle after acc.
2. Output ops:
   - Write DIR=0x00FF, OUT=0x00F0; then OUT_SET 0x000F -> OUT=0x00FF.
   - OUT_CLR 0x0081 -> 0x007E; OUT_TGL 0x00FF -> 0x0081.
   - Drive check: gpio_io[7:0]=8'h81 and gpio_io[15:8]='z.
   - IN reads 0x81 on bits 7:0 after SYNC_STAGES cycles.
3. Rising edge:
   - Set RISE_EN=0x0100, IRQ_EN=0x0100, then drive pin 8 low->high.
   - Required: STATUS=0x0100 and irq=1 exactly SYNC_STAGES edges after the first sampling edge.
   - A falling edge on pin 8 (FALL_EN=0) sets nothing further.
4. W1C and collision:
   - With STATUS=0x0100, write STATUS=0x0000 -> unchanged; write 0x0100 -> 0, and irq=0 next cycle.
   - Repeat with a pin 8 rising edge timed so the event coincides with the W1C write -> STATUS stays 0x0100.
5. Masking:
   - With STATUS=0x0003 and IRQ_EN=0 -> irq=0.
   - Write IRQ_EN=0x0002 -> irq=1 in the next cycle.
   - Write RISE_EN=FALL_EN=0 -> STATUS is still 0x0003.
6. Reset mid-operation:
   - Assert rst in the same cycle as a write OUT=0xFFFF with DIR=0xFFFF.
   - Required: OUT=0, DIR=0, rdy_=1 after the edge, pins 'z, status=0, irq=0.
   - No spurious edge event is set after rst is released.
